// File: rtl/psram_arbiter_pkg.sv
// Shared definitions for the two-port PSRAM line arbiter:
// FSM encoding and the line-address / line-buffer geometry.
package psram_arbiter_pkg;

  localparam int LINE_AW = 18;
  localparam int BUF_AW  = 2;
  localparam int BUF_DW  = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/psram_arbiter.sv
// Two-port arbiter in front of a single PSRAM line controller: port 0 is the
// CPU cache (read/write lines), port 1 is video (read lines only).
module psram_arbiter
  import psram_arbiter_pkg::*;
#(
  parameter int          P1_PRIO   = 1,
  parameter int unsigned ISSUE_TMO = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               p0_rd_req,
  input  logic               p0_wr_req,
  input  logic [LINE_AW-1:0] p0_addr,
  output logic               p0_done,
  output logic               p0_buf_en,
  output logic               p0_buf_we,
  input  logic [BUF_DW-1:0]  p0_buf_rdata,
  input  logic               p1_rd_req,
  input  logic [LINE_AW-1:0] p1_addr,
  output logic               p1_done,
  output logic               p1_buf_en,
  output logic               p1_buf_we,
  output logic [BUF_AW-1:0]  buf_addr,
  output logic [BUF_DW-1:0]  buf_wdata,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [LINE_AW-1:0] mem_raddr,
  output logic [LINE_AW-1:0] mem_waddr,
  input  logic               mem_rd_busy,
  input  logic               mem_wr_busy,
  input  logic               mem_buf_en,
  input  logic               mem_buf_we,
  input  logic [BUF_AW-1:0]  mem_buf_addr,
  input  logic [BUF_DW-1:0]  mem_buf_wdata,
  output logic [BUF_DW-1:0]  mem_buf_rdata,
  output logic               err
);

  localparam int TMO_W = (ISSUE_TMO > 0) ? $clog2(ISSUE_TMO + 1) : 1;

  state_t             r_state;
  state_t             w_next;
  logic               r_gnt;
  logic               r_wr;
  logic               r_last_gnt;
  logic [LINE_AW-1:0] r_addr;
  logic [TMO_W-1:0]   r_tmo_cnt;
  logic               r_mem_rd;
  logic               r_mem_wr;
  logic               r_p0_done;
  logic               r_p1_done;
  logic               r_err;

  logic w_p0_req;
  logic w_any_req;
  logic w_sel_p1;
  logic w_lat_wr;
  logic w_busy;
  logic w_tmo;
  logic w_active;

  assign w_p0_req  = p0_rd_req | p0_wr_req;
  assign w_any_req = w_p0_req | p1_rd_req;
  assign w_busy    = r_wr ? mem_wr_busy : mem_rd_busy;
  assign w_tmo     = (r_tmo_cnt == TMO_W'(ISSUE_TMO));

  // Round-robin only matters on a conflict: the port not granted last wins.
  always_comb begin
    w_sel_p1 = 1'b0;
    if (P1_PRIO != 0) begin
      w_sel_p1 = p1_rd_req;
    end else if (p1_rd_req && w_p0_req) begin
      w_sel_p1 = ~r_last_gnt;
    end else begin
      w_sel_p1 = p1_rd_req;
    end
  end

  // Operation for the transfer about to run; video never writes.
  always_comb begin
    w_lat_wr = r_wr;
    if (r_state == ST_IDLE) begin
      w_lat_wr = ~w_sel_p1 & p0_wr_req;
    end else begin
      w_lat_wr = r_wr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) w_next = ST_ISSUE;
        else           w_next = ST_IDLE;
      end
      ST_ISSUE: begin
        if (w_busy)     w_next = ST_BUSY;
        else if (w_tmo) w_next = ST_DONE;
        else            w_next = ST_ISSUE;
      end
      ST_BUSY: begin
        if (!w_busy) w_next = ST_DONE;
        else         w_next = ST_BUSY;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Buffer strobes reach only the granted port, and only while the controller owns the transfer.
  always_comb begin
    w_active  = (r_state == ST_ISSUE) || (r_state == ST_BUSY);
    p0_buf_en = w_active & ~r_gnt & mem_buf_en;
    p0_buf_we = w_active & ~r_gnt & mem_buf_we;
    p1_buf_en = w_active &  r_gnt & mem_buf_en;
    p1_buf_we = w_active &  r_gnt & mem_buf_we;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gnt      <= 1'b0;
      r_wr       <= 1'b0;
      r_last_gnt <= 1'b1;
      r_addr     <= '0;
      r_tmo_cnt  <= '0;
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_p0_done  <= 1'b0;
      r_p1_done  <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && w_any_req) begin
        r_gnt      <= w_sel_p1;
        r_wr       <= w_lat_wr;
        r_addr     <= w_sel_p1 ? p1_addr : p0_addr;
        r_last_gnt <= w_sel_p1;
      end
      if (r_state == ST_ISSUE && w_next == ST_ISSUE) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end else begin
        r_tmo_cnt <= '0;
      end
      // Request strobes are computed from the next state so they are clean flop outputs.
      r_mem_rd  <= (w_next == ST_ISSUE) & ~w_lat_wr;
      r_mem_wr  <= (w_next == ST_ISSUE) &  w_lat_wr;
      r_p0_done <= (w_next == ST_DONE) & ~r_gnt;
      r_p1_done <= (w_next == ST_DONE) &  r_gnt;
      r_err     <= r_err | ((r_state == ST_ISSUE) & ~w_busy & w_tmo);
    end
  end

  assign p0_done       = r_p0_done;
  assign p1_done       = r_p1_done;
  assign mem_rd        = r_mem_rd;
  assign mem_wr        = r_mem_wr;
  assign mem_raddr     = r_addr;
  assign mem_waddr     = r_addr;
  assign err           = r_err;
  assign buf_addr      = mem_buf_addr;
  assign buf_wdata     = mem_buf_wdata;
  assign mem_buf_rdata = p0_buf_rdata;

endmodule

// File: tb/tb_psram_arbiter.sv
// Scoreboard bench for psram_arbiter: a fixed-priority instance driven by a
// controller model, plus a round-robin instance for grant-order checks.
module tb_psram_arbiter;
  import psram_arbiter_pkg::*;

  localparam int TMO = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          p0_rd_req, p0_wr_req, p1_rd_req;
  logic [17:0]   p0_addr, p1_addr;
  logic          p0_done, p0_buf_en, p0_buf_we;
  logic          p1_done, p1_buf_en, p1_buf_we;
  logic [127:0]  p0_buf_rdata, buf_wdata, mem_buf_wdata, mem_buf_rdata;
  logic [1:0]    buf_addr, mem_buf_addr;
  logic          mem_rd, mem_wr, mem_rd_busy, mem_wr_busy, mem_buf_en, mem_buf_we;
  logic [17:0]   mem_raddr, mem_waddr;
  logic          err;

  logic          rr_p0_rd, rr_p0_wr, rr_p1_rd;
  logic [17:0]   rr_p0_addr, rr_p1_addr;
  logic          rr_p0_done, rr_p0_buf_en, rr_p0_buf_we;
  logic          rr_p1_done, rr_p1_buf_en, rr_p1_buf_we;
  logic [1:0]    rr_buf_addr;
  logic [127:0]  rr_buf_wdata, rr_mem_buf_rdata;
  logic          rr_mem_rd, rr_mem_wr, rr_busy, rr_err;
  logic [17:0]   rr_mem_raddr, rr_mem_waddr;

  psram_arbiter #(.P1_PRIO(1), .ISSUE_TMO(TMO)) dut (
    .clk(clk), .reset(reset),
    .p0_rd_req(p0_rd_req), .p0_wr_req(p0_wr_req), .p0_addr(p0_addr),
    .p0_done(p0_done), .p0_buf_en(p0_buf_en), .p0_buf_we(p0_buf_we),
    .p0_buf_rdata(p0_buf_rdata),
    .p1_rd_req(p1_rd_req), .p1_addr(p1_addr), .p1_done(p1_done),
    .p1_buf_en(p1_buf_en), .p1_buf_we(p1_buf_we),
    .buf_addr(buf_addr), .buf_wdata(buf_wdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_raddr(mem_raddr), .mem_waddr(mem_waddr),
    .mem_rd_busy(mem_rd_busy), .mem_wr_busy(mem_wr_busy),
    .mem_buf_en(mem_buf_en), .mem_buf_we(mem_buf_we),
    .mem_buf_addr(mem_buf_addr), .mem_buf_wdata(mem_buf_wdata),
    .mem_buf_rdata(mem_buf_rdata), .err(err)
  );

  psram_arbiter #(.P1_PRIO(0), .ISSUE_TMO(TMO)) dut_rr (
    .clk(clk), .reset(reset),
    .p0_rd_req(rr_p0_rd), .p0_wr_req(rr_p0_wr), .p0_addr(rr_p0_addr),
    .p0_done(rr_p0_done), .p0_buf_en(rr_p0_buf_en), .p0_buf_we(rr_p0_buf_we),
    .p0_buf_rdata(p0_buf_rdata),
    .p1_rd_req(rr_p1_rd), .p1_addr(rr_p1_addr), .p1_done(rr_p1_done),
    .p1_buf_en(rr_p1_buf_en), .p1_buf_we(rr_p1_buf_we),
    .buf_addr(rr_buf_addr), .buf_wdata(rr_buf_wdata),
    .mem_rd(rr_mem_rd), .mem_wr(rr_mem_wr), .mem_raddr(rr_mem_raddr), .mem_waddr(rr_mem_waddr),
    .mem_rd_busy(rr_busy), .mem_wr_busy(rr_busy),
    .mem_buf_en(rr_busy), .mem_buf_we(1'b0),
    .mem_buf_addr(2'b00), .mem_buf_wdata(mem_buf_wdata),
    .mem_buf_rdata(rr_mem_buf_rdata), .err(rr_err)
  );

  // Controller model: busy rises the cycle after a request and stays high bm_len cycles.
  int   bm_len;
  bit   bm_never;
  logic bm_busy, bm_rd;
  int   bm_cnt;
  always @(posedge clk) begin
    if (reset) begin
      bm_busy <= 1'b0; bm_rd <= 1'b0; bm_cnt <= 0;
    end else if ((mem_rd || mem_wr) && !bm_busy && !bm_never) begin
      bm_busy <= 1'b1; bm_rd <= mem_rd; bm_cnt <= bm_len - 1;
    end else if (bm_cnt > 0) begin
      bm_cnt <= bm_cnt - 1;
    end else begin
      bm_busy <= 1'b0;
    end
  end
  assign mem_rd_busy   = bm_busy & bm_rd;
  assign mem_wr_busy   = bm_busy & ~bm_rd;
  assign mem_buf_en    = bm_busy;
  assign mem_buf_we    = bm_busy & bm_rd;
  assign mem_buf_addr  = bm_cnt[1:0];
  assign mem_buf_wdata = {4{32'hA5A5_0000 | 32'(bm_cnt)}};

  always @(posedge clk) begin
    if (reset)                               rr_busy <= 1'b0;
    else if ((rr_mem_rd || rr_mem_wr) && !rr_busy) rr_busy <= 1'b1;
    else                                     rr_busy <= 1'b0;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          port;
    bit          wr;
    logic [17:0] addr;
    bit          err;
    int          mcyc;
    int          blen;
  } exp_t;

  exp_t sb[$];
  bit   rr_sb[$];

  task automatic push(input bit port, input bit wr, input logic [17:0] addr,
                      input bit e, input int mcyc, input int blen);
    exp_t x;
    x.port = port; x.wr = wr; x.addr = addr; x.err = e; x.mcyc = mcyc; x.blen = blen;
    sb.push_back(x);
  endtask

  // Monitor: accumulate per-transfer activity, compare against the scoreboard on each done.
  initial begin
    int m_rd, m_wr, m_en0, m_en1, m_we0, m_we1, m_pbad;
    logic [17:0] m_addr;
    exp_t e;
    m_rd = 0; m_wr = 0; m_en0 = 0; m_en1 = 0; m_we0 = 0; m_we1 = 0; m_pbad = 0; m_addr = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_rd = 0; m_wr = 0; m_en0 = 0; m_en1 = 0; m_we0 = 0; m_we1 = 0; m_pbad = 0;
      end else begin
        if (mem_rd) begin m_rd++; m_addr = mem_raddr; end
        if (mem_wr) begin m_wr++; m_addr = mem_waddr; end
        m_en0 += int'(p0_buf_en); m_en1 += int'(p1_buf_en);
        m_we0 += int'(p0_buf_we); m_we1 += int'(p1_buf_we);
        if (buf_addr !== mem_buf_addr || buf_wdata !== mem_buf_wdata ||
            mem_buf_rdata !== p0_buf_rdata) m_pbad++;
        if (p0_done || p1_done) begin
          if (sb.size() == 0) begin
            chk("unexpected_done", {p1_done, p0_done}, 2'b00);
          end else begin
            e = sb.pop_front();
            chk("done_port", {p1_done, p0_done}, e.port ? 2'b10 : 2'b01);
            chk("mem_wr_cycles", m_wr, e.wr ? e.mcyc : 0);
            chk("mem_rd_cycles", m_rd, e.wr ? 0 : e.mcyc);
            chk("line_addr", m_addr, e.addr);
            chk("err_flag", err, e.err);
            chk("p0_buf_en_cnt", m_en0, e.port ? 0 : e.blen);
            chk("p1_buf_en_cnt", m_en1, e.port ? e.blen : 0);
            chk("p0_buf_we_cnt", m_we0, (e.port || e.wr) ? 0 : e.blen);
            chk("p1_buf_we_cnt", m_we1, e.port ? e.blen : 0);
            chk("passthrough", m_pbad, 0);
          end
          m_rd = 0; m_wr = 0; m_en0 = 0; m_en1 = 0; m_we0 = 0; m_we1 = 0; m_pbad = 0;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && (rr_p0_done || rr_p1_done)) begin
        if (rr_sb.size() == 0) chk("rr_unexpected_done", {rr_p1_done, rr_p0_done}, 2'b00);
        else chk("rr_grant", {rr_p1_done, rr_p0_done}, rr_sb.pop_front() ? 2'b10 : 2'b01);
        chk("rr_no_write", rr_mem_wr, 1'b0);
      end
    end
  end

  // Requester behaviour: drop the served request on its done pulse (write before read).
  task automatic serve(input int n);
    int seen = 0;
    int cyc  = 0;
    while (seen < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (p0_done) begin
        seen++;
        if (p0_wr_req) p0_wr_req = 1'b0;
        else           p0_rd_req = 1'b0;
      end
      if (p1_done) begin
        seen++;
        p1_rd_req = 1'b0;
      end
    end
    chk("serve_done_count", seen, n);
  endtask

  initial begin
    int   cyc;
    bit   found;
    int   rr_seen;
    reset = 1'b1;
    p0_rd_req = 1'b0; p0_wr_req = 1'b0; p1_rd_req = 1'b0;
    p0_addr = 18'h0; p1_addr = 18'h0;
    p0_buf_rdata = {4{32'hC0DE_0123}};
    rr_p0_rd = 1'b0; rr_p0_wr = 1'b0; rr_p1_rd = 1'b0;
    rr_p0_addr = 18'h00100; rr_p1_addr = 18'h20200;
    bm_len = 2; bm_never = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_raddr", mem_raddr, 18'h0);
    chk("rst_mem_waddr", mem_waddr, 18'h0);
    chk("rst_err", err, 1'b0);
    chk("rst_done", {p1_done, p0_done}, 2'b00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // P0 write; address changes after grant must not leak through.
    bm_len = 3;
    push(1'b0, 1'b1, 18'h00123, 1'b0, 2, 3);
    p0_addr = 18'h00123; p0_wr_req = 1'b1;
    @(negedge clk);
    p0_addr = 18'h3FFFF;
    serve(1);
    repeat (2) @(negedge clk);

    // Simultaneous reads: video first under fixed priority.
    bm_len = 2;
    push(1'b1, 1'b0, 18'h21111, 1'b0, 2, 2);
    push(1'b0, 1'b0, 18'h00456, 1'b0, 2, 2);
    p0_addr = 18'h00456; p1_addr = 18'h21111;
    p0_rd_req = 1'b1; p1_rd_req = 1'b1;
    serve(2);
    repeat (2) @(negedge clk);

    // Read and write together: write first, held read follows.
    bm_len = 1;
    push(1'b0, 1'b1, 18'h0ABCD, 1'b0, 2, 1);
    push(1'b0, 1'b0, 18'h0ABCD, 1'b0, 2, 1);
    p0_addr = 18'h0ABCD; p0_rd_req = 1'b1; p0_wr_req = 1'b1;
    serve(2);
    repeat (2) @(negedge clk);

    // Busy never rises: timeout, sticky err, done still delivered.
    bm_never = 1'b1;
    push(1'b1, 1'b0, 18'h30F0F, 1'b1, TMO + 1, 0);
    p1_addr = 18'h30F0F; p1_rd_req = 1'b1;
    serve(1);
    bm_never = 1'b0;
    @(negedge clk);
    chk("err_sticky", err, 1'b1);
    bm_len = 2;
    push(1'b0, 1'b0, 18'h00010, 1'b1, 2, 2);
    p0_addr = 18'h00010; p0_rd_req = 1'b1;
    serve(1);
    repeat (2) @(negedge clk);

    // Reset while the controller is busy: aborted, no done pulse.
    bm_len = 6;
    p0_addr = 18'h00777; p0_rd_req = 1'b1;
    found = 1'b0;
    cyc = 0;
    while (!found && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (mem_rd_busy && !mem_rd && cyc > 3) found = 1'b1;
    end
    chk("reached_busy", found, 1'b1);
    reset = 1'b1; p0_rd_req = 1'b0;
    @(negedge clk);
    chk("abort_mem_rd", mem_rd, 1'b0);
    chk("abort_mem_wr", mem_wr, 1'b0);
    chk("abort_err", err, 1'b0);
    chk("abort_done", {p1_done, p0_done}, 2'b00);
    reset = 1'b0;
    repeat (8) @(negedge clk);
    bm_len = 2;
    push(1'b1, 1'b0, 18'h2AAAA, 1'b0, 2, 2);
    p1_addr = 18'h2AAAA; p1_rd_req = 1'b1;
    serve(1);
    repeat (2) @(negedge clk);

    // Round-robin with both ports requesting continuously.
    rr_sb.push_back(1'b0); rr_sb.push_back(1'b1);
    rr_sb.push_back(1'b0); rr_sb.push_back(1'b1);
    rr_p0_rd = 1'b1; rr_p1_rd = 1'b1;
    rr_seen = 0;
    cyc = 0;
    while (rr_seen < 4 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (rr_p0_done || rr_p1_done) rr_seen++;
      if (rr_seen == 4) begin rr_p0_rd = 1'b0; rr_p1_rd = 1'b0; end
    end
    chk("rr_done_count", rr_seen, 4);

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    chk("rr_sb_drained", rr_sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/psram_arbiter.md
PSRAM_ARBITER -- requirements
Module: psram_arbiter

Interface
REQ-001 SHALL have parameter P1_PRIO, default 1: 1 = port 1 (video) has fixed priority; 0 = round-robin.
REQ-002 SHALL have parameter ISSUE_TMO, default 15: maximum clk cycles to wait for controller busy after issue.
REQ-003 clk  in  1  system clock, same net as the controller mem_clk; arbiter uses the rising edge.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 p0_rd_req, p0_wr_req  in  1 each  port 0 (CPU cache) line read/write request, level, held until p0_done.
REQ-006 p0_addr  in  18 [23:6]  port 0 line address.
REQ-007 p0_done  out  1  one-cycle pulse when port 0 transfer is complete.
REQ-008 p0_buf_en, p0_buf_we  out  1 each  port 0 line-buffer strobes.
REQ-009 p0_buf_rdata  in  128  port 0 line-buffer write-back data.
REQ-010 p1_rd_req  in  1  port 1 (video) line read request, level; p1_addr  in  18  line address; p1_done  out  1  pulse.
REQ-011 p1_buf_en, p1_buf_we  out  1 each  port 1 line-buffer strobes.
REQ-012 buf_addr  out  2; buf_wdata  out  128  shared line-buffer address/data, broadcast to both ports.
REQ-013 mem_rd, mem_wr  out  1 each; mem_raddr, mem_waddr  out  18  controller request side.
REQ-014 mem_rd_busy, mem_wr_busy  in  1 each; mem_buf_en, mem_buf_we  in  1 each; mem_buf_addr  in  2; mem_buf_wdata  in  128; mem_buf_rdata  out  128  controller buffer side.
REQ-015 err  out  1  sticky issue-timeout flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, BUSY, DONE.
REQ-017 IDLE: if any request is pending, SHALL latch grant (gnt: 0/1), operation (rd/wr) and address, then go to ISSUE; otherwise stay.
REQ-018 Arbitration with P1_PRIO=1: p1 wins when p1_rd_req=1; else p0, where p0_wr_req wins over p0_rd_req.
REQ-019 Arbitration with P1_PRIO=0: on a conflict, the port not granted last SHALL win; last-grant resets to port 1 so port 0 wins the first conflict.
REQ-020 ISSUE: SHALL drive mem_rd or mem_wr high with the latched address on mem_raddr/mem_waddr; SHALL go to BUSY on the first cycle the matching busy input is high.
REQ-021 ISSUE timeout: SHALL count cycles in ISSUE; at count ISSUE_TMO with busy still low, SHALL set err, drop mem_rd/mem_wr, and go to DONE.
REQ-022 BUSY: mem_rd/mem_wr SHALL be low, so the controller does not re-trigger; on the first cycle busy is low, SHALL go to DONE.
REQ-023 DONE: SHALL pulse pN_done of the granted port for exactly one cycle, then return to IDLE.
REQ-024 A request still high in the cycle after done SHALL be treated as a new request; requesters drop req on done.
REQ-025 Steering, combinational: mem_buf_en/mem_buf_we SHALL go to pN_buf_en/pN_buf_we of the granted port only; the other port's strobes SHALL be 0.
REQ-026 Steering: buf_addr = mem_buf_addr and buf_wdata = mem_buf_wdata at all times; mem_buf_rdata = p0_buf_rdata.
REQ-027 Strobes SHALL be forwarded in ISSUE and BUSY only; in IDLE and DONE all pN_buf_* SHALL be 0.
REQ-028 Port 1 SHALL never cause mem_wr to assert.
REQ-029 Simultaneous p0_rd_req and p0_wr_req SHALL be served as a write; the read stays pending.
REQ-030 Latched grant and address SHALL NOT change between leaving IDLE and DONE, even if requests or addresses change.

Reset
REQ-031 On reset, state = IDLE and mem_rd = mem_wr = 0.
REQ-032 On reset, mem_raddr = mem_waddr = 0, all done pulses = 0, err = 0, timeout counter = 0, last-grant = 1.
REQ-033 Reset mid-transfer SHALL abort with no done pulse; the controller shares the reset, so it also re-initializes.

Structure
REQ-034 A shared package SHALL hold the state encoding and the 18-bit line-address width constant (LINE_AW = 18).
REQ-035 No sub-module: the arbiter is a single module; the priority select is inline logic.

Verification
REQ-036 P0 write at addr 18'h00123 with busy high 3 cycles then low -> mem_wr=1 in ISSUE only, mem_waddr=18'h00123, one p0_done pulse, p0_buf_en mirrors mem_buf_en.
REQ-037 P0 rd and P1 rd asserted together, P1_PRIO=1 -> P1 served first (p1_done), then P0 (p0_done); p0 strobes 0 during the P1 transfer.
REQ-038 P1_PRIO=0, both ports requesting continuously for 4 transfers -> grant sequence P0, P1, P0, P1.
REQ-039 Busy never rises after issue -> err=1 after ISSUE_TMO+1 cycles, done pulse for the granted port, return to IDLE.
REQ-040 Reset asserted while in BUSY -> next cycle IDLE, mem_rd/mem_wr=0, no done pulse, err=0.
REQ-041 p0_rd_req and p0_wr_req both high -> mem_wr first; after p0_done, with rd_req still held, a mem_rd transfer follows.
